// File: rtl/vm_pkg.sv
// Shared types and constants for the change dispenser: FSM states,
// coin indices and the default denomination values.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EJECT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] COIN_Q = 2'd0;
  localparam logic [1:0] COIN_D = 2'd1;
  localparam logic [1:0] COIN_N = 2'd2;
  localparam logic [1:0] COIN_P = 2'd3;

  localparam logic [7:0] COIN0_DEF = 8'd25;
  localparam logic [7:0] COIN1_DEF = 8'd10;
  localparam logic [7:0] COIN2_DEF = 8'd5;
  localparam logic [7:0] COIN3_DEF = 8'd1;

endpackage

// File: rtl/coin_picker.sv
// Combinational greedy search: lowest-index (largest) denomination that
// fits in the remaining amount and whose tube is not empty.
module coin_picker
  import vm_pkg::*;
(
  input  logic [7:0] remaining,
  input  logic [3:0] coin_empty,
  input  logic [7:0] val0,
  input  logic [7:0] val1,
  input  logic [7:0] val2,
  input  logic [7:0] val3,
  output logic       found,
  output logic [1:0] sel
);

  always_comb begin
    found = 1'b0;
    sel   = COIN_Q;
    if (val0 <= remaining && !coin_empty[0]) begin
      found = 1'b1;
      sel   = COIN_Q;
    end else if (val1 <= remaining && !coin_empty[1]) begin
      found = 1'b1;
      sel   = COIN_D;
    end else if (val2 <= remaining && !coin_empty[2]) begin
      found = 1'b1;
      sel   = COIN_N;
    end else if (val3 <= remaining && !coin_empty[3]) begin
      found = 1'b1;
      sel   = COIN_P;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Drains a credit amount as a serial stream of coin-eject requests,
// largest coin first, flagging a shortfall when exact change is impossible.
module change_dispenser
  import vm_pkg::*;
#(
  parameter logic [7:0] COIN0_VAL = COIN0_DEF,
  parameter logic [7:0] COIN1_VAL = COIN1_DEF,
  parameter logic [7:0] COIN2_VAL = COIN2_DEF,
  parameter logic [7:0] COIN3_VAL = COIN3_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic [3:0] coin_empty,
  input  logic       coin_ready,
  output logic       coin_valid,
  output logic [1:0] coin_sel,
  output logic       busy,
  output logic       done,
  output logic       short_chg,
  output logic [7:0] remaining
);

  state_t     state;
  logic       found;
  logic [1:0] pick_sel;
  logic [7:0] sel_val;

  coin_picker u_picker (
    .remaining  (remaining),
    .coin_empty (coin_empty),
    .val0       (COIN0_VAL),
    .val1       (COIN1_VAL),
    .val2       (COIN2_VAL),
    .val3       (COIN3_VAL),
    .found      (found),
    .sel        (pick_sel)
  );

  // Value of the coin currently being ejected, subtracted on the handshake.
  always_comb begin
    case (coin_sel)
      COIN_Q:  sel_val = COIN0_VAL;
      COIN_D:  sel_val = COIN1_VAL;
      COIN_N:  sel_val = COIN2_VAL;
      default: sel_val = COIN3_VAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      coin_valid <= 1'b0;
      coin_sel   <= COIN_Q;
      busy       <= 1'b0;
      done       <= 1'b0;
      short_chg  <= 1'b0;
      remaining  <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= amount;
            short_chg <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (remaining == 8'd0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (found) begin
            coin_sel   <= pick_sel;
            coin_valid <= 1'b1;
            state      <= ST_EJECT;
          end else begin
            // Nothing fits: stop with the unpaid amount left visible.
            short_chg <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_EJECT: begin
          if (coin_ready) begin
            remaining  <= remaining - sel_val;
            coin_valid <= 1'b0;
            state      <= ST_SELECT;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
